// File: rtl/clock_gen_pkg.sv
// Shared constants for the multi-channel clock divider: output modes and
// the divide-ratio floor/reset value.
package clock_gen_pkg;

  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;
  localparam int   DIV_MIN     = 2;
  localparam int   DIV_RESET   = 2;

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: wrap counter, active ratio/mode and a single pending
// update slot that is applied on wrap, on SYNC, or while disabled.
module clock_div_chan
  import clock_gen_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sync,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          load_mode,
  output logic          int_clk,
  output logic          tick,
  output logic          ack
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] div_r;
  logic          mode_r;
  logic          pend_v;
  logic [CW-1:0] pend_val;
  logic          pend_mode;

  logic          wrap;
  logic [CW-1:0] cnt_next;
  logic          apply;
  logic [CW-1:0] load_clamped;

  always_comb begin
    wrap         = (cnt == div_r - CW'(1));
    cnt_next     = wrap ? '0 : cnt + CW'(1);
    apply        = pend_v && (sync || !en || wrap);
    load_clamped = (load_val < CW'(DIV_MIN)) ? CW'(DIV_MIN) : load_val;
  end

  // A load on the same edge as an apply lands in the slot after the old
  // pending value has been consumed, so it waits for the next wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      div_r     <= CW'(DIV_RESET);
      mode_r    <= MODE_PULSE;
      pend_v    <= 1'b0;
      pend_val  <= CW'(DIV_RESET);
      pend_mode <= MODE_PULSE;
      int_clk   <= 1'b0;
      tick      <= 1'b0;
      ack       <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (sync || !en) begin
        cnt     <= '0;
        int_clk <= 1'b0;
        tick    <= 1'b0;
      end else begin
        cnt     <= cnt_next;
        tick    <= wrap;
        int_clk <= (mode_r == MODE_SQUARE) ? (cnt_next >= div_r - (div_r >> 1)) : wrap;
      end
      if (apply) begin
        div_r  <= pend_val;
        mode_r <= pend_mode;
        pend_v <= 1'b0;
        ack    <= 1'b1;
      end
      if (load) begin
        pend_v    <= 1'b1;
        pend_val  <= load_clamped;
        pend_mode <= load_mode;
      end
    end
  end

endmodule

// File: rtl/clock_div_gen.sv
// Multi-channel internal clock/enable generator: decodes ratio updates to
// per-channel dividers and flags loads aimed at non-existent channels.
module clock_div_gen
  import clock_gen_pkg::*;
#(
  parameter int NCH = 2,
  parameter int CW  = 8,
  parameter int CHW = 1
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [NCH-1:0] EN,
  input  logic           SYNC,
  input  logic           DIV_LOAD,
  input  logic [CHW-1:0] DIV_CH,
  input  logic [CW-1:0]  DIV_VAL,
  input  logic           DIV_MODE,
  output logic [NCH-1:0] DIV_ACK,
  output logic           DIV_ERR,
  output logic [NCH-1:0] INT_CLK,
  output logic [NCH-1:0] TICK
);

  logic ch_invalid;

  assign ch_invalid = (int'(DIV_CH) >= NCH);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) DIV_ERR <= 1'b0;
    else       DIV_ERR <= DIV_LOAD && ch_invalid;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clock_div_chan #(.CW(CW)) u_chan (
      .clk       (CLK),
      .rst       (RESET),
      .en        (EN[i]),
      .sync      (SYNC),
      .load      (DIV_LOAD && (int'(DIV_CH) == i)),
      .load_val  (DIV_VAL),
      .load_mode (DIV_MODE),
      .int_clk   (INT_CLK[i]),
      .tick      (TICK[i]),
      .ack       (DIV_ACK[i])
    );
  end

endmodule

// File: tb/tb_clock_div_gen.sv
// Self-checking bench for clock_div_gen: reference model feeding a scoreboard
// queue, a table of stimulus segments, and hand-coded corner sequences.
module tb_clock_div_gen;

  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int CHW = 2;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] en;
  logic           sync;
  logic           div_load;
  logic [CHW-1:0] div_ch;
  logic [CW-1:0]  div_val;
  logic           div_mode;
  logic [NCH-1:0] div_ack;
  logic           div_err;
  logic [NCH-1:0] int_clk;
  logic [NCH-1:0] tick;

  clock_div_gen #(.NCH(NCH), .CW(CW), .CHW(CHW)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .EN       (en),
    .SYNC     (sync),
    .DIV_LOAD (div_load),
    .DIV_CH   (div_ch),
    .DIV_VAL  (div_val),
    .DIV_MODE (div_mode),
    .DIV_ACK  (div_ack),
    .DIV_ERR  (div_err),
    .INT_CLK  (int_clk),
    .TICK     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] int_clk;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] ack;
    logic           err;
  } exp_t;

  typedef struct {
    logic [NCH-1:0] en;
    logic           sync;
    logic           load;
    logic [CHW-1:0] ch;
    logic [CW-1:0]  val;
    logic           mode;
    int             n;
    int             et0;
    int             et1;
    int             eh1;
  } vec_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  int m_cnt[NCH];
  int m_div[NCH];
  int m_pval[NCH];
  bit m_mode[NCH];
  bit m_pv[NCH];
  bit m_pmode[NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i]   = 0;
      m_div[i]   = 2;
      m_mode[i]  = 1'b0;
      m_pv[i]    = 1'b0;
      m_pval[i]  = 2;
      m_pmode[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [NCH-1:0] e_en, input logic e_sync, input logic e_load,
                            input logic [CHW-1:0] e_ch, input logic [CW-1:0] e_val, input logic e_mode);
    exp_t e;
    e = '0;
    for (int i = 0; i < NCH; i++) begin
      bit w;
      bit ap;
      int nxt;
      w   = (m_cnt[i] == m_div[i] - 1);
      nxt = w ? 0 : m_cnt[i] + 1;
      ap  = m_pv[i] && (e_sync || !e_en[i] || w);
      if (e_sync || !e_en[i]) begin
        m_cnt[i] = 0;
      end else begin
        m_cnt[i]     = nxt;
        e.tick[i]    = w;
        e.int_clk[i] = m_mode[i] ? (nxt >= m_div[i] - m_div[i] / 2) : w;
      end
      if (ap) begin
        m_div[i]  = m_pval[i];
        m_mode[i] = m_pmode[i];
        m_pv[i]   = 1'b0;
        e.ack[i]  = 1'b1;
      end
      if (e_load && (int'(e_ch) == i)) begin
        m_pv[i]    = 1'b1;
        m_pval[i]  = (int'(e_val) < 2) ? 2 : int'(e_val);
        m_pmode[i] = e_mode;
      end
    end
    e.err = e_load && (int'(e_ch) >= NCH);
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic [NCH-1:0] c_en, input logic c_sync, input logic c_load,
                       input logic [CHW-1:0] c_ch, input logic [CW-1:0] c_val, input logic c_mode);
    exp_t e;
    exp_t a;
    @(negedge clk);
    en       = c_en;
    sync     = c_sync;
    div_load = c_load;
    div_ch   = c_ch;
    div_val  = c_val;
    div_mode = c_mode;
    model_step(c_en, c_sync, c_load, c_ch, c_val, c_mode);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    a = {int_clk, tick, div_ack, div_err};
    check("cycle_outputs", 32'(a), 32'(e));
  endtask

  vec_t tbl[19];

  initial begin
    logic [3:0]  h4_clk;
    logic [3:0]  h4_tick;
    logic [14:0] h_t0;
    logic [14:0] h_t1;
    logic [6:0]  h_ack0;
    logic [6:0]  h_clk0;

    //          en      sy    ld    ch     val    md    n   t0  t1  h1
    tbl[0]  = '{3'b111, 1'b0, 1'b1, 2'd0, 8'd5,  1'b0, 1,  -1, -1, -1};
    tbl[1]  = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0,  1'b0, 5,  -1, -1, -1};
    tbl[2]  = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0,  1'b0, 10,  2,  5,  5};
    tbl[3]  = '{3'b111, 1'b0, 1'b1, 2'd1, 8'd4,  1'b1, 1,  -1, -1, -1};
    tbl[4]  = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0,  1'b0, 3,  -1, -1, -1};
    tbl[5]  = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0,  1'b0, 20,  4,  5, 10};
    tbl[6]  = '{3'b111, 1'b0, 1'b1, 2'd1, 8'd3,  1'b1, 1,  -1, -1, -1};
    tbl[7]  = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0,  1'b0, 4,  -1, -1, -1};
    tbl[8]  = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0,  1'b0, 15,  3,  5,  5};
    tbl[9]  = '{3'b111, 1'b0, 1'b1, 2'd0, 8'd0,  1'b0, 1,  -1, -1, -1};
    tbl[10] = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0,  1'b0, 5,  -1, -1, -1};
    tbl[11] = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0,  1'b0, 12,  6,  4,  4};
    tbl[12] = '{3'b111, 1'b0, 1'b1, 2'd3, 8'd9,  1'b1, 1,  -1, -1, -1};
    tbl[13] = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0,  1'b0, 12,  6,  4,  4};
    tbl[14] = '{3'b111, 1'b0, 1'b1, 2'd0, 8'd3,  1'b0, 1,  -1, -1, -1};
    tbl[15] = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0,  1'b0, 6,  -1, -1, -1};
    tbl[16] = '{3'b111, 1'b0, 1'b1, 2'd1, 8'd5,  1'b0, 1,  -1, -1, -1};
    tbl[17] = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0,  1'b0, 6,  -1, -1, -1};
    tbl[18] = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0,  1'b0, 15,  5,  3,  3};

    rst      = 1'b1;
    en       = '1;
    sync     = 1'b0;
    div_load = 1'b0;
    div_ch   = '0;
    div_val  = '0;
    div_mode = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({int_clk, tick, div_ack, div_err}), 32'd0);
    rst = 1'b0;

    // Legacy divide-by-2 after reset, then async reset while INT_CLK is high
    for (int k = 0; k < 4; k++) begin
      cycle(3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
      h4_clk[k]  = int_clk[0];
      h4_tick[k] = tick[0];
    end
    check("legacy_int_clk0", 32'(h4_clk), 32'b1010);
    check("legacy_tick0", 32'(h4_tick), 32'b1010);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 32'({int_clk, tick, div_ack, div_err}), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int v = 0; v < 19; v++) begin
      int t0;
      int t1;
      int h1;
      t0 = 0;
      t1 = 0;
      h1 = 0;
      for (int k = 0; k < tbl[v].n; k++) begin
        if (k == 0) cycle(tbl[v].en, tbl[v].sync, tbl[v].load, tbl[v].ch, tbl[v].val, tbl[v].mode);
        else        cycle(tbl[v].en, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
        t0 += int'(tick[0]);
        t1 += int'(tick[1]);
        h1 += int'(int_clk[1]);
      end
      if (tbl[v].et0 >= 0) check($sformatf("vec%0d_tick0_count", v), 32'(t0), 32'(tbl[v].et0));
      if (tbl[v].et1 >= 0) check($sformatf("vec%0d_tick1_count", v), 32'(t1), 32'(tbl[v].et1));
      if (tbl[v].eh1 >= 0) check($sformatf("vec%0d_high1_count", v), 32'(h1), 32'(tbl[v].eh1));
    end

    // SYNC with a pending ch1 update: both restart in phase, ch1 ACKed by SYNC
    cycle(3'b111, 1'b0, 1'b1, 2'd1, 8'd5, 1'b0);
    cycle(3'b111, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
    check("sync_outputs_low", 32'({int_clk[1:0], tick[1:0]}), 32'd0);
    check("sync_ack", 32'(div_ack[1:0]), 32'b10);
    for (int k = 0; k < 15; k++) begin
      cycle(3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
      h_t0[k] = tick[0];
      h_t1[k] = tick[1];
    end
    check("sync_tick0_pattern", 32'(h_t0), 32'b100100100100100);
    check("sync_tick1_pattern", 32'(h_t1), 32'b100001000010000);

    // EN[0] low for 7 cycles with a load in the middle, then re-enable
    for (int k = 0; k < 7; k++) begin
      if (k == 2) cycle(3'b110, 1'b0, 1'b1, 2'd0, 8'd4, 1'b0);
      else        cycle(3'b110, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
      h_clk0[k] = int_clk[0];
      h_ack0[k] = div_ack[0];
    end
    check("disabled_int_clk0", 32'(h_clk0), 32'd0);
    check("disabled_ack0", 32'(h_ack0), 32'b0001000);
    for (int k = 0; k < 4; k++) begin
      cycle(3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
      h4_tick[k] = tick[0];
      h4_clk[k]  = int_clk[0];
    end
    check("reenable_tick0", 32'(h4_tick), 32'b1000);
    check("reenable_int_clk0", 32'(h4_clk), 32'b1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
